// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: shares one single-ported data memory between the
// MEM-stage CPU access and a DMA/debug requester. The CPU wins by default; a
// saturating starvation counter forces a DMA grant after STARVE_LIMIT
// consecutive CPU grants taken while DMA was waiting.
module dmem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_rd_i,
    input  logic              cpu_wr_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_stall_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_ack_o,
    input  logic              dma_req_i,
    input  logic              dma_we_i,
    input  logic [ADDR_W-1:0] dma_addr_i,
    input  logic [DATA_W-1:0] dma_wdata_i,
    output logic              dma_done_o,
    output logic [DATA_W-1:0] dma_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_BUSY = 2'd1,
        DMA_BUSY = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state, state_nxt;
    logic       cpu_req;
    logic       grant_cpu;
    logic       grant_dma;
    logic [3:0] cnt;

    // A simultaneous read+write request is issued as a write.
    assign cpu_req     = cpu_rd_i | cpu_wr_i;
    // CPU completion is combinational so MEM/WB captures read data on the ack edge.
    assign cpu_ack_o   = (state == CPU_BUSY) & mem_ack_i;
    assign cpu_rdata_o = mem_rdata_i;
    assign cpu_stall_o = cpu_req & ~cpu_ack_o;

    // Next-state and grant decision; grants are only made from IDLE.
    always_comb begin
        state_nxt = state;
        grant_cpu = 1'b0;
        grant_dma = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req && (!dma_req_i || cnt < LIMIT)) begin
                    grant_cpu = 1'b1;
                    state_nxt = CPU_BUSY;
                end else if (dma_req_i) begin
                    grant_dma = 1'b1;
                    state_nxt = DMA_BUSY;
                end
            end
            CPU_BUSY, DMA_BUSY: begin
                if (mem_ack_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    // Latch the winner's transaction on grant and hold it until the memory acks.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else if (grant_cpu) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= cpu_wr_i;
            mem_addr_o  <= cpu_addr_i;
            mem_wdata_o <= cpu_wdata_i;
        end else if (grant_dma) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= dma_we_i;
            mem_addr_o  <= dma_addr_i;
            mem_wdata_o <= dma_wdata_i;
        end else if (state != IDLE && mem_ack_i) begin
            mem_req_o   <= 1'b0;
        end
    end

    // DMA completion is registered: one-cycle done pulse plus held read data.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            dma_done_o  <= 1'b0;
            dma_rdata_o <= '0;
        end else begin
            dma_done_o <= (state == DMA_BUSY) & mem_ack_i;
            if (state == DMA_BUSY && mem_ack_i) dma_rdata_o <= mem_rdata_i;
        end
    end

    // Starvation counter: counts CPU grants taken while DMA waits.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt <= 4'd0;
        end else if (grant_cpu) begin
            if (dma_req_i) cnt <= (cnt >= LIMIT) ? LIMIT : cnt + 4'd1;
            else           cnt <= 4'd0;
        end else if (grant_dma) begin
            cnt <= 4'd0;
        end
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Sequences the single-ported data memory behind the EX/MEM stage register and shares it with a secondary DMA/debug requester.
- Holds each granted transaction stable until the memory acknowledges it, and stalls the pipeline while the MEM-stage access is outstanding.
- CPU has priority; a starvation counter guarantees DMA progress.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_LIMIT, 4, consecutive CPU grants with DMA waiting before DMA is forced (1..15)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-low reset
cpu_rd_i  in  1  MEM-stage read request (Mem_o[1] of EX/MEM)
cpu_wr_i  in  1  MEM-stage write request (Mem_o[0] of EX/MEM)
cpu_addr_i  in  ADDR_W  Memaddr_o of EX/MEM
cpu_wdata_i  in  DATA_W  Memdata_o of EX/MEM
cpu_stall_o  out  1  freeze PC/IF/ID/EX/EX-MEM this cycle
cpu_rdata_o  out  DATA_W  read data, valid when cpu_ack_o=1
cpu_ack_o  out  1  CPU access completes this cycle
dma_req_i  in  1  DMA request, level, held until dma_done_o
dma_we_i  in  1  1 = write
dma_addr_i  in  ADDR_W  DMA address
dma_wdata_i  in  DATA_W  DMA write data
dma_done_o  out  1  one-cycle pulse, DMA access finished
dma_rdata_o  out  DATA_W  registered DMA read data
mem_req_o  out  1  memory request, held until mem_ack_i
mem_we_o  out  1  memory write enable
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_ack_i  in  1  memory completes the current request (may be in the first req cycle)
mem_rdata_i  in  DATA_W  read data, valid with mem_ack_i

Behaviour:
- FSM states: IDLE, CPU_BUSY, DMA_BUSY.
- Reset (rst_i=0, async): state IDLE. mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, dma_done_o, dma_rdata_o, starve counter all 0.
  - Reset during BUSY abandons the transaction; no ack or done is produced for it.
- IDLE arbitration, evaluated at each rising edge:
  - cpu_req = cpu_rd_i | cpu_wr_i.
  - If cpu_req and (!dma_req_i or cnt < STARVE_LIMIT): grant CPU, go to CPU_BUSY.
  - Else if dma_req_i: grant DMA, go to DMA_BUSY.
  - Else stay in IDLE.
- On grant, register mem_addr_o/mem_wdata_o/mem_we_o from the winner and set mem_req_o=1.
  - A CPU request with cpu_rd_i and cpu_wr_i both high is treated as a write.
- BUSY states: mem_req_o and the registered fields are held stable. On a cycle with mem_ack_i=1:
  - mem_req_o drops at the next edge.
  - State returns to IDLE. No back-to-back grant from BUSY; minimum one IDLE cycle between transactions.
- CPU completion (combinational):
  - cpu_ack_o = (state==CPU_BUSY) & mem_ack_i.
  - cpu_rdata_o = mem_rdata_i (passthrough, captured by MEM/WB on the same edge).
- cpu_stall_o = cpu_req & !cpu_ack_o.
  - Minimum CPU access is therefore 2 cycles: IDLE plus a CPU_BUSY cycle with immediate ack, stalling 1 cycle.
- DMA completion (registered): on the ack edge in DMA_BUSY, dma_done_o=1 for exactly one cycle and dma_rdata_o captures mem_rdata_i (write: captures too, value don't-care).
  - dma_rdata_o holds until the next DMA completion.
- Starve counter (4 bits):
  - On a CPU grant while dma_req_i=1: cnt += 1, saturating at STARVE_LIMIT.
  - On a CPU grant with dma_req_i=0, or on any DMA grant: cnt = 0.
- Request inputs changing while in BUSY are ignored; the latched transaction completes unchanged.
- CPU request withdrawn in IDLE before grant (e.g. a flush): no access is issued.
- Read and write latency is set solely by mem_ack_i timing; there is no timeout.

Test Plan:
- Reset: drive rst_i=0 mid-CPU_BUSY with mem_req_o=1 -> mem_req_o=0 immediately (async); after release, state IDLE and cnt=0.
- CPU read, ack in first BUSY cycle: cpu_rd_i=1, addr=0x40, mem_rdata_i=0xDEADBEEF -> mem_req_o high 1 cycle, cpu_stall_o high 1 cycle, cpu_ack_o with cpu_rdata_o=0xDEADBEEF in cycle 2.
- CPU write with 3-cycle ack delay: addr=0x80, wdata=0x12345678 -> mem_we_o=1 and addr/wdata stable for 3 cycles; cpu_stall_o high 3 cycles; ack in cycle 4.
- Simultaneous CPU+DMA, cnt=0: CPU granted first; DMA granted at the next IDLE; dma_done_o pulses once with dma_rdata_o = mem_rdata_i.
- Starvation, STARVE_LIMIT=4: dma_req_i held high, cpu_rd_i held high continuously -> grant order CPU,CPU,CPU,CPU,DMA; cnt=0 after the DMA grant.
- Both cpu_rd_i and cpu_wr_i high -> mem_we_o=1. cpu_req dropped in IDLE -> mem_req_o never rises.
